imem_program_loader: RTL and testbench

- Writer side of the instruction memory, which the CPU only ever reads.
- Receives a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words.
- Checks each word's opcode against the set the control unit decodes, then writes legal words to consecutive instruction-memory addresses.
- Holds the CPU (forces PC update off) until a complete, legal program ending in halt has been loaded.

---
 rtl/imem_program_loader_if.sv | 22 ++
 rtl/imem_program_loader.sv | 155 +++++++++++++++
 tb/tb_imem_program_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = byte source / memory side, slave = loader.
interface imem_program_loader_if #(
   parameter int ADDR_W = 8
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_program_loader.sv
// Packs a big-endian byte stream into 32-bit words, checks opcodes and writes
// legal words to consecutive instruction-memory addresses; holds the CPU until done.
module imem_program_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 start,
   imem_program_loader_if.slave bus,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [5:0]           err_opcode,
   output logic [ADDR_W:0]      word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            r_state;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_shift;
   logic              r_byte_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_cpu_hold;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [5:0]        r_err_opcode;
   logic [ADDR_W:0]   r_word_count;

   logic [31:0]       w_word_in;
   logic              w_accept;
   logic              w_in_legal;
   logic              w_cur_legal;
   logic [ADDR_W:0]   w_count_inc;
   logic              w_last;

   function automatic logic legal_op(input logic [5:0] op);
      case (op)
         6'b000000, 6'b000001, 6'b000010,
         6'b010000, 6'b010001, 6'b010010,
         6'b100000, 6'b100110, 6'b100111,
         6'b110000, 6'b111111: legal_op = 1'b1;
         default:              legal_op = 1'b0;
      endcase
   endfunction

   assign w_word_in   = {r_shift[23:0], bus.byte_data};
   assign w_accept    = r_byte_ready & bus.byte_valid;
   assign w_in_legal  = legal_op(w_word_in[31:26]);
   assign w_cur_legal = legal_op(r_shift[31:26]);
   assign w_count_inc = r_word_count + 1'b1;
   assign w_last      = (r_shift[31:26] == 6'b111111) ||
                        (w_count_inc == (ADDR_W+1)'(MAX_WORDS));

   // The write strobe is set up while byte 3 is accepted so it is registered
   // and visible during the single WRITE cycle that follows.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_byte_cnt   <= '0;
         r_shift      <= '0;
         r_byte_ready <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_hold   <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_opcode <= '0;
         r_word_count <= '0;
      end else begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_state      <= S_LOAD;
                  r_byte_cnt   <= '0;
                  r_shift      <= '0;
                  r_byte_ready <= 1'b1;
                  r_cpu_hold   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_err_opcode <= '0;
                  r_word_count <= '0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_shift <= w_word_in;
                  if (r_byte_cnt == 2'd3) begin
                     r_byte_cnt   <= '0;
                     r_byte_ready <= 1'b0;
                     r_state      <= S_WRITE;
                     if (w_in_legal) begin
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_W'(BASE_ADDR) + r_word_count[ADDR_W-1:0];
                        r_wdata <= w_word_in;
                     end
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               if (w_cur_legal) begin
                  r_word_count <= w_count_inc;
                  if (w_last) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                     r_busy     <= 1'b0;
                  end else begin
                     r_state      <= S_LOAD;
                     r_byte_ready <= 1'b1;
                  end
               end else begin
                  r_state      <= S_ERROR;
                  r_err        <= 1'b1;
                  r_err_opcode <= r_shift[31:26];
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.byte_ready = r_byte_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign cpu_hold       = r_cpu_hold;
   assign busy           = r_busy;
   assign done           = r_done;
   assign err            = r_err;
   assign err_opcode     = r_err_opcode;
   assign word_count     = r_word_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: randomized byte streams scored
// against a word-level reference model of the load protocol.
module tb_imem_program_loader;

   logic CLK = 1'b0;
   logic Reset, start, start4;
   always #5 CLK = ~CLK;

   imem_program_loader_if #(.ADDR_W(8)) bus ();
   imem_program_loader_if #(.ADDR_W(4)) bus4 ();

   logic       cpu_hold, busy, done, err;
   logic [5:0] err_opcode;
   logic [8:0] word_count;
   logic       cpu_hold4, busy4, done4, err4;
   logic [5:0] err_opcode4;
   logic [4:0] word_count4;

   imem_program_loader #(.ADDR_W(8), .MAX_WORDS(256), .BASE_ADDR(0)) u_dut (
      .CLK(CLK), .Reset(Reset), .start(start), .bus(bus),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
      .err_opcode(err_opcode), .word_count(word_count)
   );

   imem_program_loader #(.ADDR_W(4), .MAX_WORDS(4), .BASE_ADDR(4)) u_dut4 (
      .CLK(CLK), .Reset(Reset), .start(start4), .bus(bus4),
      .cpu_hold(cpu_hold4), .busy(busy4), .done(done4), .err(err4),
      .err_opcode(err_opcode4), .word_count(word_count4)
   );

   int checks = 0;
   int errors = 0;

   logic [5:0] legal_tbl [0:10] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12,
                                     6'h20, 6'h26, 6'h27, 6'h30, 6'h3F};

   // monitors
   int          cyc = 0;
   int          wr_addr_q[$], wr_cyc_q[$], acc_cyc_q[$], wr4_addr_q[$];
   logic [31:0] wr_data_q[$], wr4_data_q[$];
   logic [7:0]  acc_q[$];
   int          acc4_n = 0, rdy_in_wr = 0, we_long = 0;
   logic        prev_we = 1'b0;

   always @(posedge CLK) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr_q.push_back(int'(bus.imem_addr));
         wr_data_q.push_back(bus.imem_wdata);
         wr_cyc_q.push_back(cyc);
         if (bus.byte_ready !== 1'b0) rdy_in_wr++;
         if (prev_we) we_long++;
      end
      prev_we = (bus.imem_we === 1'b1);
      if (bus.byte_valid && bus.byte_ready) begin
         acc_q.push_back(bus.byte_data);
         acc_cyc_q.push_back(cyc);
      end
      if (bus4.imem_we === 1'b1) begin
         wr4_addr_q.push_back(int'(bus4.imem_addr));
         wr4_data_q.push_back(bus4.imem_wdata);
      end
      if (bus4.byte_valid && bus4.byte_ready) acc4_n++;
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: word-level interpretation of the byte stream
   logic [7:0]  byte_q[$];
   int          exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   bit          exp_done, exp_err;
   logic [5:0]  exp_opc;
   int          exp_cnt, exp_nbytes;

   function automatic bit is_legal(input logic [5:0] op);
      foreach (legal_tbl[i]) if (legal_tbl[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_run(input int max_words, input int base);
      int i, cnt;
      logic [31:0] w;
      bit fin;
      exp_addr_q.delete(); exp_data_q.delete();
      exp_done = 0; exp_err = 0; exp_opc = '0; i = 0; cnt = 0; fin = 0;
      while (!fin && i + 4 <= byte_q.size()) begin
         w = {byte_q[i], byte_q[i+1], byte_q[i+2], byte_q[i+3]};
         i += 4;
         if (is_legal(w[31:26])) begin
            exp_addr_q.push_back(base + cnt);
            exp_data_q.push_back(w);
            cnt++;
            if (w[31:26] == 6'h3F || cnt == max_words) begin exp_done = 1; fin = 1; end
         end else begin
            exp_err = 1; exp_opc = w[31:26]; fin = 1;
         end
      end
      exp_cnt = cnt; exp_nbytes = i;
   endtask

   task automatic add_word(input logic [31:0] w);
      byte_q.push_back(w[31:24]); byte_q.push_back(w[23:16]);
      byte_q.push_back(w[15:8]);  byte_q.push_back(w[7:0]);
   endtask

   task automatic clear_mon();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      acc_q.delete(); acc_cyc_q.delete(); wr4_addr_q.delete(); wr4_data_q.delete();
      acc4_n = 0; rdy_in_wr = 0; we_long = 0;
   endtask

   task automatic drive(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin bus4.byte_valid = v; bus4.byte_data = d; end
      else     begin bus.byte_valid  = v; bus.byte_data  = d; end
   endtask

   task automatic do_reset();
      Reset = 1'b1; start = 1'b0; start4 = 1'b0;
      drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00);
      repeat (2) @(posedge CLK);
      #1 Reset = 1'b0;
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) start4 = 1'b1; else start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; start4 = 1'b0;
   endtask

   task automatic send_stream(input bit sel, input int first, input int last, input int gap_pct);
      bit ok, rdy;
      for (int k = first; k < last; k++) begin
         if ($urandom_range(99) < gap_pct) begin
            drive(sel, 1'b0, 8'h00);
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
         end
         drive(sel, 1'b1, byte_q[k]);
         ok = 0;
         for (int t = 0; t < 50 && !ok; t++) begin
            rdy = sel ? bus4.byte_ready : bus.byte_ready;
            @(posedge CLK); #1;
            ok = rdy;
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout byte %0d not accepted within 50 cycles", k);
            drive(sel, 1'b0, 8'h00);
            return;
         end
      end
      drive(sel, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %0b exp 1", cpu_hold); end
      checks++; if ({busy, done, err, bus.byte_ready, bus.imem_we} !== 5'b0)
         begin errors++; $display("FAIL rst_flags got %b exp 00000", {busy, done, err, bus.byte_ready, bus.imem_we}); end
      checks++; if (word_count !== 9'd0 || err_opcode !== 6'd0)
         begin errors++; $display("FAIL rst_counts got wc=%0d op=%0d exp 0 0", word_count, err_opcode); end
   endtask

   task automatic test_basic();
      clear_mon(); byte_q.delete();
      add_word(32'h04010005); add_word(32'hFC000000);
      model_run(256, 0);
      pulse_start(0);
      send_stream(0, 0, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != exp_addr_q.size())
         begin errors++; $display("FAIL basic_nwrites got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); end
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         checks++; if (wr_addr_q[i] != exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
            begin errors++; $display("FAIL basic_write%0d got %h@%0d exp %h@%0d", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]); end
      end
      checks++; if (we_long != 0) begin errors++; $display("FAIL basic_we_width got %0d long strobes exp 0", we_long); end
      checks++; if (wr_cyc_q.size() < 1 || acc_cyc_q.size() < 4 || wr_cyc_q[0] != acc_cyc_q[3] + 1)
         begin errors++; $display("FAIL basic_latency write strobe not one cycle after byte 3"); end
      checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
         begin errors++; $display("FAIL basic_status got done=%b hold=%b busy=%b err=%b exp 1 0 0 0", done, cpu_hold, busy, err); end
      checks++; if (word_count !== 9'(exp_cnt))
         begin errors++; $display("FAIL basic_word_count got %0d exp %0d", word_count, exp_cnt); end
   endtask

   task automatic test_illegal();
      clear_mon(); byte_q.delete();
      add_word(32'h0C000000);
      model_run(256, 0);
      pulse_start(0);
      send_stream(0, 0, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL ill_nowrite got %0d writes exp 0", wr_addr_q.size()); end
      checks++; if (err !== exp_err || err_opcode !== exp_opc)
         begin errors++; $display("FAIL ill_err got err=%b op=%b exp %b %b", err, err_opcode, exp_err, exp_opc); end
      checks++; if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL ill_status got hold=%b rdy=%b done=%b exp 1 0 0", cpu_hold, bus.byte_ready, done); end
      pulse_start(0);
      checks++; if (err !== 1'b0 || word_count !== 9'd0 || err_opcode !== 6'd0 || busy !== 1'b1)
         begin errors++; $display("FAIL ill_recover got err=%b wc=%0d op=%0d busy=%b exp 0 0 0 1", err, word_count, err_opcode, busy); end
      do_reset();
   endtask

   task automatic test_random_stream();
      int nw;
      logic [5:0] op;
      for (int it = 0; it < 10; it++) begin
         clear_mon(); byte_q.delete();
         nw = $urandom_range(1, 6);
         for (int w = 0; w < nw; w++) begin
            if (w == nw - 1) op = 6'h3F;
            else if ($urandom_range(9) == 0) begin
               do op = 6'($urandom); while (is_legal(op));
            end else op = legal_tbl[$urandom_range(9)];
            add_word({op, 26'($urandom)});
         end
         model_run(256, 0);
         pulse_start(0);
         send_stream(0, 0, exp_nbytes, 30);
         repeat (2) @(posedge CLK); #1;
         checks++; if (acc_q.size() != exp_nbytes)
            begin errors++; $display("FAIL rnd%0d_accepts got %0d exp %0d", it, acc_q.size(), exp_nbytes); end
         for (int i = 0; i < exp_nbytes && i < acc_q.size(); i++)
            if (acc_q[i] !== byte_q[i]) begin
               checks++; errors++;
               $display("FAIL rnd%0d_byte%0d got %h exp %h", it, i, acc_q[i], byte_q[i]);
            end
         checks++; if (wr_addr_q.size() != exp_addr_q.size())
            begin errors++; $display("FAIL rnd%0d_nwrites got %0d exp %0d", it, wr_addr_q.size(), exp_addr_q.size()); end
         for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] != exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
               begin errors++; $display("FAIL rnd%0d_write%0d got %h@%0d exp %h@%0d", it, i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]); end
         end
         checks++; if (done !== exp_done || err !== exp_err || err_opcode !== exp_opc || word_count !== 9'(exp_cnt))
            begin errors++; $display("FAIL rnd%0d_status got done=%b err=%b op=%h wc=%0d exp %b %b %h %0d", it, done, err, err_opcode, word_count, exp_done, exp_err, exp_opc, exp_cnt); end
         checks++; if (rdy_in_wr != 0 || we_long != 0)
            begin errors++; $display("FAIL rnd%0d_write_cycle got ready_in_write=%0d long=%0d exp 0 0", it, rdy_in_wr, we_long); end
      end
      do_reset();
   endtask

   task automatic test_max_words();
      clear_mon(); byte_q.delete();
      repeat (4) add_word(32'h00221800);
      add_word(32'hFC000000);
      model_run(4, 4);
      pulse_start(1);
      send_stream(1, 0, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr4_addr_q.size() != 4 || exp_addr_q.size() != 4)
         begin errors++; $display("FAIL max_nwrites got %0d exp 4", wr4_addr_q.size()); end
      for (int i = 0; i < exp_addr_q.size() && i < wr4_addr_q.size(); i++) begin
         checks++; if (wr4_addr_q[i] != exp_addr_q[i] || wr4_data_q[i] !== exp_data_q[i])
            begin errors++; $display("FAIL max_write%0d got %h@%0d exp %h@%0d", i, wr4_data_q[i], wr4_addr_q[i], exp_data_q[i], exp_addr_q[i]); end
      end
      checks++; if (done4 !== 1'b1 || word_count4 !== 5'd4 || cpu_hold4 !== 1'b0)
         begin errors++; $display("FAIL max_status got done=%b wc=%0d hold=%b exp 1 4 0", done4, word_count4, cpu_hold4); end
      drive(1, 1'b1, 8'hFC);
      repeat (10) @(posedge CLK); #1;
      checks++; if (acc4_n != 16 || bus4.byte_ready !== 1'b0)
         begin errors++; $display("FAIL max_no_more_bytes got accepts=%0d rdy=%b exp 16 0", acc4_n, bus4.byte_ready); end
      drive(1, 1'b0, 8'h00);
   endtask

   task automatic test_reset_midload();
      clear_mon(); byte_q.delete();
      add_word(32'h04010005);
      pulse_start(0);
      send_stream(0, 0, 2, 0);
      do_reset();
      repeat (3) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != 0 || cpu_hold !== 1'b1 || busy !== 1'b0 || bus.byte_ready !== 1'b0)
         begin errors++; $display("FAIL midrst_state got writes=%0d hold=%b busy=%b rdy=%b exp 0 1 0 0", wr_addr_q.size(), cpu_hold, busy, bus.byte_ready); end
      clear_mon(); byte_q.delete();
      add_word(32'hFC000000);
      model_run(256, 0);
      pulse_start(0);
      send_stream(0, 0, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0])
         begin errors++; $display("FAIL midrst_write got %0d writes, first %h exp %h@%0d", wr_addr_q.size(), wr_data_q.size() ? wr_data_q[0] : 32'h0, exp_data_q[0], exp_addr_q[0]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got %b exp 1", done); end
   endtask

   task automatic test_start_ignored();
      do_reset();
      clear_mon(); byte_q.delete();
      add_word(32'h04010005); add_word(32'hFC000000);
      model_run(256, 0);
      pulse_start(0);
      send_stream(0, 0, 2, 0);
      pulse_start(0);
      send_stream(0, 2, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != 2 || wr_addr_q[1] != exp_addr_q[1] || wr_data_q[0] !== exp_data_q[0] || wr_data_q[1] !== exp_data_q[1])
         begin errors++; $display("FAIL ign_writes got %0d writes exp 2 matching the model", wr_addr_q.size()); end
      checks++; if (done !== 1'b1 || word_count !== 9'd2)
         begin errors++; $display("FAIL ign_status got done=%b wc=%0d exp 1 2", done, word_count); end
      pulse_start(0);
      checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1 || word_count !== 9'd0)
         begin errors++; $display("FAIL restart_status got done=%b hold=%b busy=%b wc=%0d exp 0 1 1 0", done, cpu_hold, busy, word_count); end
      clear_mon(); byte_q.delete();
      add_word(32'hFC000000);
      model_run(256, 0);
      send_stream(0, 0, exp_nbytes, 0);
      repeat (2) @(posedge CLK); #1;
      checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0])
         begin errors++; $display("FAIL restart_write got %0d writes exp 1 at %0d", wr_addr_q.size(), exp_addr_q[0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_random_stream();
      test_max_words();
      test_reset_midload();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
